// File: rtl/mem_access_ctl.sv
// Load/store access controller between a core and a fixed-latency word memory (big-endian lanes).
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned lw/sw with err instead of silently aligning.
module mem_access_ctl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        halted,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_write_en
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;
  localparam logic [3:0] LAT    = 4'(MEM_LATENCY);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  wbyte_q;
  logic        bad_q;
  logic        busy_q, done_q, err_q, mem_write_en_q;
  logic [31:0] rdata_q, mem_addr_q, mem_data_in_q;
  logic        accept_s, reject_s, misalign_s;

  // Lane k is byte offset k; lane 0 sits in the most significant byte.
  function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    lane_get = w[31:24];
      2'd1:    lane_get = w[23:16];
      2'd2:    lane_get = w[15:8];
      2'd3:    lane_get = w[7:0];
      default: lane_get = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    case (k)
      2'd0:    lane_put = {b, w[23:0]};
      2'd1:    lane_put = {w[31:24], b, w[15:0]};
      2'd2:    lane_put = {w[31:16], b, w[7:0]};
      2'd3:    lane_put = {w[31:8], b};
      default: lane_put = w;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] o, input logic [31:0] w,
                                           input logic [1:0] k);
    logic [7:0] b;
    b = lane_get(w, k);
    case (o)
      OP_LB:   load_fmt = {{24{b[7]}}, b};
      OP_LBU:  load_fmt = {24'h000000, b};
      default: load_fmt = w;
    endcase
  endfunction

  // Request qualification: acceptance window and early rejection of bad requests.
  always_comb begin
    accept_s   = 1'b0;
    misalign_s = 1'b0;
    if ((state_q == IDLE) && req && !halted) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
`ifdef MEM_ALIGN_CHECK_EN
    if (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
`else
    misalign_s = 1'b0;
`endif
    reject_s = (op > OP_SB) || misalign_s;
  end

  // Access sequencer; rejected requests pass through WR with the strobe suppressed.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      op_q           <= 3'd0;
      off_q          <= 2'd0;
      wbyte_q        <= 8'h00;
      bad_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      mem_write_en_q <= 1'b0;
      rdata_q        <= 32'h0;
      mem_addr_q     <= 32'h0;
      mem_data_in_q  <= 32'h0;
    end else begin
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      mem_write_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            busy_q     <= 1'b1;
            mem_addr_q <= {addr[31:2], 2'b00};
            op_q       <= op;
            off_q      <= addr[1:0];
            wbyte_q    <= wdata[7:0];
            cnt_q      <= 4'd1;
            if (reject_s) begin
              bad_q   <= 1'b1;
              state_q <= WR;
            end else if (op == OP_SW) begin
              bad_q          <= 1'b0;
              mem_write_en_q <= 1'b1;
              mem_data_in_q  <= wdata;
              state_q        <= WR;
            end else begin
              bad_q   <= 1'b0;
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == LAT) begin
            if (op_q == OP_SB) begin
              mem_write_en_q <= 1'b1;
              mem_data_in_q  <= lane_put(mem_data_out, off_q, wbyte_q);
              state_q        <= WR;
            end else begin
              rdata_q <= load_fmt(op_q, mem_data_out, off_q);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WR: begin
          done_q  <= 1'b1;
          err_q   <= bad_q;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_write_en = mem_write_en_q;

endmodule

// File: doc/mem_access_ctl.md
MEM_ACCESS_CTL -- requirements
Module: mem_access_ctl

Interface
REQ-001 Parameter MEM_LATENCY, default 1, cycles from a stable mem_addr to valid mem_data_out; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  core requests a memory operation.
REQ-005 op  input  3  000 lw, 001 sw, 010 lb, 011 lbu, 100 sb; 101-111 illegal.
REQ-006 addr  input  32  byte address.
REQ-007 wdata  input  32  store data; sb uses wdata[7:0].
REQ-008 halted  input  1  core halted; blocks acceptance of new requests.
REQ-009 busy  output  1  operation in flight; high from the accept edge until the edge that raises done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  valid with done; illegal op or misaligned access.
REQ-012 rdata  output  32  load result, valid with done; held until the next done.
REQ-013 mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-014 mem_data_in  output  4x8  store bytes; lane 0 = byte offset 0 = word bits 31:24 (big-endian).
REQ-015 mem_data_out  input  4x8  read bytes; same lane order.
REQ-016 mem_write_en  output  1  memory write strobe.

Function
REQ-017 States SHALL be IDLE, RD_WAIT, WR and DONE.
REQ-018 Accept (edge E0): state IDLE, req=1 and halted=0; addr, op and wdata SHALL be latched and held internally until done.
REQ-019 While busy=1 or halted=1, req SHALL be ignored and not queued.
REQ-020 mem_addr SHALL stay stable from E0 until done rises.
REQ-021 lw/lb/lbu: IDLE->RD_WAIT for MEM_LATENCY cycles; mem_data_out captured at E0+MEM_LATENCY; DONE (done=1) for the following cycle; then IDLE.
REQ-022 lw: rdata = {lane0,lane1,lane2,lane3}. lb: lane[addr[1:0]] sign-extended. lbu: same lane zero-extended.
REQ-023 sw: IDLE->WR. mem_write_en=1 and mem_data_in=wdata bytes for exactly the cycle E0..E0+1; done rises at E0+1.
REQ-024 sb (read-modify-write): RD_WAIT as in REQ-021, then WR for one cycle. mem_data_in = captured word with lane addr[1:0] replaced by wdata[7:0]. done rises at E0+MEM_LATENCY+1.
REQ-025 Illegal op: no memory access, mem_write_en stays 0; err=1 with done at E0+1; rdata unchanged.
REQ-026 mem_write_en SHALL be asserted only in WR; never more than once per operation.
REQ-027 For stores, rdata SHALL be unchanged.
REQ-028 done and err SHALL be 0 in every cycle where done is not pulsed.
REQ-029 A req asserted in the DONE cycle SHALL be ignored; it is accepted the following cycle if still asserted.
REQ-030 halted asserted mid-operation SHALL NOT abort the operation; it completes normally.

Reset
REQ-031 rst_b=0 SHALL immediately force IDLE: busy=0, done=0, err=0, mem_write_en=0, rdata=0, mem_addr=0, mem_data_in=0, cycle counter=0.
REQ-032 Reset during RD_WAIT or WR SHALL abandon the operation with no done and no further write.
REQ-033 First accept is possible on the first rising edge after rst_b deasserts.

Configuration
REQ-034 Macro MEM_ALIGN_CHECK_EN defined: lw/sw with addr[1:0]!=0 produces no memory access and err=1 with done at E0+1.
REQ-035 MEM_ALIGN_CHECK_EN undefined: addr[1:0] is ignored for lw/sw, which proceed as aligned with err=0.

Verification
REQ-036 MEM_LATENCY=2, mem word 0x11223344 at 0x100; lw 0x100 accepted at E0 -> done at E0+2, rdata=0x11223344, err=0.
REQ-037 Same word; lb 0x103 -> rdata=0x00000044; word 0x80FF0000, lb 0x100 -> 0xFFFFFF80; lbu 0x100 -> 0x00000080.
REQ-038 sb 0x101 with wdata=0xAB over 0x11223344 -> single mem_write_en pulse at E0+2 with data 0x11AB3344; done at E0+3.
REQ-039 sw 0x102 with MEM_ALIGN_CHECK_EN -> err=1, done at E0+1, no write; without macro -> write to 0x100, err=0.
REQ-040 rst_b pulled low during RD_WAIT of sb -> no mem_write_en and no done; all outputs 0; next lw completes normally.
REQ-041 op=111 -> err=1 at E0+1; req held during busy/DONE and halted=1 -> no second accept.
